// File: rtl/tty_serial_tx.sv
// Teletype-style async serial transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits,
// clocked by rising edges of an oversampled baud clock. Define TTY_TX_PARITY_EN to send even parity as bit 7.
module tty_serial_tx #(
    parameter int STOP_BITS     = 2,
    parameter int TICKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic [7:0] data,
    input  logic       load,
    input  logic       flag_clr,
    output logic       serial,
    output logic       busy,
    output logic       flag
);

    localparam int SW = $clog2(TICKS_PER_BIT);
    localparam logic [SW-1:0] SUB_LAST  = SW'(TICKS_PER_BIT - 1);
    localparam logic [SW-1:0] SUB_ONE   = SW'(1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Character actually shifted out; bit 7 optionally replaced by even parity of the low seven bits.
    function automatic logic [7:0] frame_byte(input logic [7:0] d);
`ifdef TTY_TX_PARITY_EN
        frame_byte = {^d[6:0], d[6:0]};
`else
        frame_byte = d;
`endif
    endfunction

    state_t          r_state;
    logic [SW-1:0]   r_sub;
    logic [2:0]      r_bitcnt;
    logic            r_stopcnt;
    logic [7:0]      r_shift;
    logic            r_baud_q;
    logic            r_serial;
    logic            r_busy;
    logic            r_flag;
    logic            w_tick;
    logic            w_cell_end;

    assign w_tick     = baud_clk & ~r_baud_q;
    assign w_cell_end = w_tick & (r_sub == SUB_LAST);

    assign serial = r_serial;
    assign busy   = r_busy;
    assign flag   = r_flag;

    // Framing FSM; flag_clr is applied first so a frame-end set on the same edge overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sub     <= '0;
            r_bitcnt  <= 3'd0;
            r_stopcnt <= 1'b0;
            r_shift   <= 8'd0;
            r_baud_q  <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_baud_q <= baud_clk;
            if (flag_clr) begin
                r_flag <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    if (load) begin
                        r_shift <= frame_byte(data);
                        r_busy  <= 1'b1;
                        r_flag  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_tick) begin
                        r_serial <= 1'b0;
                        r_sub    <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_cell_end) begin
                        r_sub    <= '0;
                        r_serial <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= 3'd0;
                        r_state  <= S_DATA;
                    end else if (w_tick) begin
                        r_sub <= r_sub + SUB_ONE;
                    end
                end
                S_DATA: begin
                    if (w_cell_end) begin
                        r_sub <= '0;
                        if (r_bitcnt == 3'd7) begin
                            r_serial  <= 1'b1;
                            r_stopcnt <= 1'b0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_serial <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                        end
                    end else if (w_tick) begin
                        r_sub <= r_sub + SUB_ONE;
                    end
                end
                S_STOP: begin
                    r_serial <= 1'b1;
                    if (w_cell_end) begin
                        r_sub <= '0;
                        if (r_stopcnt == STOP_LAST) begin
                            r_busy  <= 1'b0;
                            r_flag  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_stopcnt <= r_stopcnt + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_sub <= r_sub + SUB_ONE;
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
